shift_register_universal: RTL and testbench



---
 rtl/shift_register_universal.sv | 124 ++++++++++++
 tb/tb_shift_register_universal.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_register_universal.sv
// shift_register_universal: loadable word store with multi-cycle shift/rotate
// commands, one bit position per clock, and a start/busy/done handshake.
module shift_register_universal #(
  parameter int              WIDTH       = 4,
  parameter int              AMT_W       = 3,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amount,
  input  logic [WIDTH-1:0] data_in,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q_out,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    OP_LOAD  = 3'b000,
    OP_SHL   = 3'b001,
    OP_SHR   = 3'b010,
    OP_ROL   = 3'b011,
    OP_ROR   = 3'b100,
    OP_ASR   = 3'b101,
    OP_CLEAR = 3'b110,
    OP_NOP   = 3'b111
  } op_t;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  state_t           state_next;
  op_t              op_cur;
  op_t              op_reg;
  logic [AMT_W-1:0] cnt;
  logic             accept;
  logic             is_shift;
  logic             launch;
  logic             last_step;
  logic [WIDTH-1:0] step_q;
  logic             step_so;

  assign op_cur = op_t'(op);

  // Command decode: acceptance and whether it needs the multi-cycle path
  always_comb begin
    accept    = (state == IDLE) && start;
    is_shift  = (op_cur == OP_SHL) || (op_cur == OP_SHR) || (op_cur == OP_ROL) ||
                (op_cur == OP_ROR) || (op_cur == OP_ASR);
    launch    = accept && is_shift && (amount != '0);
    last_step = (state == RUN) && (cnt == AMT_W'(1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (launch)    state_next = RUN;
      RUN:     if (last_step) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state == RUN);
  end

  // One step of the latched shift command applied to the current word
  always_comb begin
    step_q  = q_out;
    step_so = serial_out;
    unique case (op_reg)
      OP_SHL: begin step_q = {q_out[WIDTH-2:0], serial_in};   step_so = q_out[WIDTH-1]; end
      OP_SHR: begin step_q = {serial_in, q_out[WIDTH-1:1]};   step_so = q_out[0];       end
      OP_ROL: begin step_q = {q_out[WIDTH-2:0], q_out[WIDTH-1]}; step_so = q_out[WIDTH-1]; end
      OP_ROR: begin step_q = {q_out[0], q_out[WIDTH-1:1]};    step_so = q_out[0];       end
      OP_ASR: begin step_q = {q_out[WIDTH-1], q_out[WIDTH-1:1]}; step_so = q_out[0];    end
      default: begin step_q = q_out; step_so = serial_out; end
    endcase
  end

  // Datapath: word, serial output, step counter, latched op and done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      q_out      <= RESET_VALUE;
      serial_out <= 1'b0;
      done       <= 1'b0;
      cnt        <= '0;
      op_reg     <= OP_NOP;
    end else begin
      done <= 1'b0;
      if (state == RUN) begin
        q_out      <= step_q;
        serial_out <= step_so;
        cnt        <= cnt - AMT_W'(1);
        if (last_step) done <= 1'b1;
      end else if (accept) begin
        unique case (op_cur)
          OP_LOAD:  q_out <= data_in;
          OP_CLEAR: begin
            q_out      <= '0;
            serial_out <= 1'b0;
          end
          default:  ;
        endcase
        op_reg <= op_cur;
        cnt    <= amount;
        // single-cycle ops and zero-amount shifts finish at the accept edge
        if (!launch) done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_shift_register_universal.sv
// Testbench for shift_register_universal: directed plan plus randomized
// commands, checked through a done-triggered scoreboard.
module tb_shift_register_universal;

  localparam int W = 4;
  localparam int A = 3;
  localparam int MASK = (1 << W) - 1;

  localparam logic [2:0] LOAD  = 3'b000;
  localparam logic [2:0] SHL   = 3'b001;
  localparam logic [2:0] SHR   = 3'b010;
  localparam logic [2:0] ROL   = 3'b011;
  localparam logic [2:0] ROR   = 3'b100;
  localparam logic [2:0] ASR   = 3'b101;
  localparam logic [2:0] CLEAR = 3'b110;
  localparam logic [2:0] NOP   = 3'b111;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b111;
  logic [A-1:0] amount = '0;
  logic [W-1:0] data_in = '0;
  logic         serial_in = 1'b0;
  logic [W-1:0] q_out;
  logic         serial_out;
  logic         busy;
  logic         done;

  shift_register_universal #(
    .WIDTH(W),
    .AMT_W(A),
    .RESET_VALUE(4'b0000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .op(op),
    .amount(amount),
    .data_in(data_in),
    .serial_in(serial_in),
    .q_out(q_out),
    .serial_out(serial_out),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic         so;
    int           busy_len;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // behavioural model state
  int unsigned mq = 0;
  int unsigned mso = 0;

  task automatic check(input string name, input int unsigned got, input int unsigned exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // one shift step on the model word, written as plain arithmetic
  task automatic model_step(input logic [2:0] o, input int unsigned si);
    int unsigned msb, lsb;
    msb = (mq >> (W - 1)) & 1;
    lsb = mq & 1;
    case (o)
      SHL: begin mso = msb; mq = ((mq * 2) + si) & MASK; end
      SHR: begin mso = lsb; mq = (mq / 2) + si * (1 << (W - 1)); end
      ROL: begin mso = msb; mq = ((mq * 2) + msb) & MASK; end
      ROR: begin mso = lsb; mq = (mq / 2) + lsb * (1 << (W - 1)); end
      ASR: begin mso = lsb; mq = (mq / 2) + msb * (1 << (W - 1)); end
      default: ;
    endcase
  endtask

  // Issue one command; call between edges while the DUT is idle.
  // si < 0 gives a random serial_in on each step.
  task automatic issue(input logic [2:0] o, input int amt, input logic [W-1:0] d, input int si);
    exp_t e;
    bit   shift;
    start   = 1'b1;
    op      = o;
    amount  = A'(amt);
    data_in = d;
    @(posedge clk);
    shift = (o >= SHL) && (o <= ASR);
    case (o)
      LOAD:  mq = d;
      CLEAR: begin mq = 0; mso = 0; end
      default: ;
    endcase
    if (shift && amt > 0) begin
      for (int i = 0; i < amt; i++) begin
        #2;
        // garbage commands while busy must be ignored
        start     = 1'($urandom_range(0, 1));
        op        = 3'($urandom);
        amount    = A'($urandom);
        data_in   = W'($urandom);
        serial_in = (si < 0) ? 1'($urandom_range(0, 1)) : si[0];
        @(posedge clk);
        model_step(o, 32'(serial_in));
      end
    end
    e.q        = W'(mq);
    e.so       = mso[0];
    e.busy_len = (shift && amt > 0) ? amt : 0;
    sb.push_back(e);
    #2;
    start = 1'b0;
  endtask

  // Monitor: counts busy cycles and scores each done pulse
  int busy_cnt = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("q_out", 32'(q_out), 32'(e.q));
          check("serial_out", 32'(serial_out), 32'(e.so));
          check("busy_len", busy_cnt, e.busy_len);
          check("busy_at_done", 32'(busy), 0);
        end
        busy_cnt = 0;
      end else if (!busy) begin
        busy_cnt = 0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // reset overrides a concurrent start/LOAD
    reset   = 1'b1;
    start   = 1'b1;
    op      = LOAD;
    data_in = 4'b0011;
    repeat (3) @(posedge clk);
    #2;
    check("rst_q", 32'(q_out), 0);
    check("rst_done", 32'(done), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_so", 32'(serial_out), 0);
    reset = 1'b0;
    mq = 0;
    mso = 0;

    issue(LOAD, 0, 4'b0011, 0);
    issue(SHL, 2, 4'b0000, 0);     // 0110, 1100
    issue(LOAD, 0, 4'b1010, 0);
    issue(ASR, 3, 4'b0000, 0);     // 1101, 1110, 1111
    issue(LOAD, 0, 4'b0011, 0);
    issue(ROL, 4, 4'b1111, 0);     // back to 0011
    issue(LOAD, 0, 4'b1111, 0);

    // reset in the middle of SHR by 3
    start     = 1'b1;
    op        = SHR;
    amount    = 3'd3;
    serial_in = 1'b0;
    @(posedge clk);
    #2;
    start = 1'b0;
    @(posedge clk);
    #2;
    check("mid_step1_q", 32'(q_out), 32'h7);
    check("mid_step1_busy", 32'(busy), 1);
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    check("mid_rst_q", 32'(q_out), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_so", 32'(serial_out), 0);
    check("mid_rst_done", 32'(done), 0);
    mq = 0;
    mso = 0;
    @(posedge clk);
    #2;
    check("mid_rst_done2", 32'(done), 0);
    check("mid_rst_busy2", 32'(busy), 0);

    issue(LOAD, 0, 4'b0101, 0);
    issue(SHR, 0, 4'b0000, 1);     // no change
    issue(ROR, 1, 4'b0000, 0);     // serial_out = 1
    issue(CLEAR, 0, 4'b0000, 0);
    issue(NOP, 0, 4'b1111, 0);

    // randomized commands, including amounts beyond the word width
    for (int n = 0; n < 250; n++) begin
      issue(3'($urandom), int'($urandom_range(0, (1 << A) - 1)), W'($urandom), -1);
    end

    repeat (3) @(posedge clk);
    #2;
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
